// File: rtl/fetch_queue_if.sv
// Fetch queue bus: imem read port, redirect request and decode-side instruction handshake.
// The master modport is the fetch_queue side; the slave modport is the imem/core side.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned OccW = $clog2(DEPTH) + 1;

  logic [31:0]     imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [31:0]     instr_pc;
  logic            instr_ready;
  logic [OccW-1:0] occupancy;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    output occupancy
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    input  occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, reads imem once per cycle and buffers
// {pc, instr} pairs in a small FIFO; a redirect flushes the queue and restarts fetch.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic          i_clk,
  input logic          i_reset,
  fetch_queue_if.master bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [31:0]     r_fetch_pc;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;
  logic [31:0]     r_mem_instr [DEPTH];
  logic [31:0]     r_mem_pc    [DEPTH];

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CntFull);
  assign w_pop   = w_valid & bus.instr_ready & ~bus.redirect;
  // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
  assign w_push  = ~bus.redirect & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (bus.redirect) begin
      r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed while the count says it is valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) begin
      r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = r_mem_instr[r_rd_ptr];
  assign bus.instr_pc    = r_mem_pc[r_rd_ptr];
  assign bus.occupancy   = r_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed per-cycle vector table for the listed
// scenarios, then randomized traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // imem holds its own word index at every word.
  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return a >> 2;
  endfunction

  assign bus.imem_rdata = imem_fn(bus.imem_addr);

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    int unsigned eocc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic r, input logic d, input logic [31:0] p, input logic y,
                     input logic c, input logic v, input logic [31:0] epc,
                     input int unsigned occ, input logic [31:0] addr);
    vec_t t;
    t.rst = r; t.rdr = d; t.rpc = p; t.rdy = y;
    t.chk = c; t.ev = v; t.epc = epc; t.eocc = occ; t.eaddr = addr;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic ev, input logic [31:0] epc,
                               input int unsigned eocc, input logic [31:0] eaddr);
    check("instr_valid", idx, 32'(bus.instr_valid), 32'(ev));
    check("occupancy", idx, 32'(bus.occupancy), eocc);
    check("imem_addr", idx, bus.imem_addr, eaddr);
    if (ev) begin
      check("instr_pc", idx, bus.instr_pc, epc);
      check("instr", idx, bus.instr, imem_fn(epc));
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic [31:0] p, input logic y);
    rst = r;
    bus.redirect = d;
    bus.redirect_pc = p;
    bus.instr_ready = y;
  endtask

  // Reference model: queue of fetched PCs plus the fetch address.
  logic [31:0] m_q[$];
  logic [31:0] m_fpc;

  task automatic model_step(input logic r, input logic d, input logic [31:0] p,
                            input logic y);
    if (r) begin
      m_q.delete();
      m_fpc = 32'h0;
    end else if (d) begin
      m_q.delete();
      m_fpc = p & 32'hFFFF_FFFC;
    end else begin
      if (m_q.size() > 0 && y) void'(m_q.pop_front());
      if (m_q.size() < DEPTH) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  initial begin
    // Scenario 1: streaming with instr_ready held high
    add(1,0,0,1, 0,0,0,0,0);
    add(0,0,0,1, 1,0,0,0,0);
    add(0,0,0,1, 1,1,32'h0,1,32'h4);
    add(0,0,0,1, 1,1,32'h4,1,32'h8);
    add(0,0,0,1, 1,1,32'h8,1,32'hC);
    // Scenario 2: stall 10 cycles, fill, freeze, then drain without gap
    add(1,0,0,0, 0,0,0,0,0);
    add(0,0,0,0, 1,0,0,0,0);
    add(0,0,0,0, 1,1,32'h0,1,32'h4);
    add(0,0,0,0, 1,1,32'h0,2,32'h8);
    add(0,0,0,0, 1,1,32'h0,3,32'hC);
    for (int i = 0; i < 6; i++) add(0,0,0,0, 1,1,32'h0,4,32'h10);
    add(0,0,0,1, 1,1,32'h0,4,32'h10);
    add(0,0,0,1, 1,1,32'h4,4,32'h14);
    add(0,0,0,1, 1,1,32'h8,4,32'h18);
    add(0,0,0,1, 1,1,32'hC,4,32'h1C);
    add(0,0,0,1, 1,1,32'h10,4,32'h20);
    // Scenario 3: full, one-cycle ready pops and pushes together
    add(0,0,0,0, 1,1,32'h14,4,32'h24);
    add(0,0,0,1, 1,1,32'h14,4,32'h24);
    add(0,0,0,0, 1,1,32'h18,4,32'h28);
    // Scenario 4: redirect to 0x23 with ready high; head is discarded
    add(0,1,32'h23,1, 1,1,32'h18,4,32'h28);
    add(0,0,0,1, 1,0,0,0,32'h20);
    add(0,0,0,1, 1,1,32'h20,1,32'h24);
    // Scenario 5: back-to-back redirects, last wins
    add(0,1,32'h40,1, 1,1,32'h24,1,32'h28);
    add(0,1,32'h80,1, 1,0,0,0,32'h40);
    add(0,0,0,1, 1,0,0,0,32'h80);
    add(0,0,0,1, 1,1,32'h80,1,32'h84);
    add(0,0,0,1, 1,1,32'h84,1,32'h88);
    // Scenario 6: fill, then reset while full
    add(0,0,0,0, 1,1,32'h88,1,32'h8C);
    add(0,0,0,0, 1,1,32'h88,2,32'h90);
    add(0,0,0,0, 1,1,32'h88,3,32'h94);
    add(0,0,0,0, 1,1,32'h88,4,32'h98);
    add(1,0,0,1, 1,1,32'h88,4,32'h98);
    add(0,0,0,0, 1,0,0,0,32'h0);
    add(0,0,0,0, 1,1,32'h0,1,32'h4);
    // Fetch PC wrap past 0xFFFFFFFC
    add(0,1,32'hFFFF_FFFB,1, 1,1,32'h0,2,32'h8);
    add(0,0,0,1, 1,0,0,0,32'hFFFF_FFF8);
    add(0,0,0,1, 1,1,32'hFFFF_FFF8,1,32'hFFFF_FFFC);
    add(0,0,0,1, 1,1,32'hFFFF_FFFC,1,32'h0);
    add(0,0,0,1, 1,1,32'h0,1,32'h4);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdr, tbl[i].rpc, tbl[i].rdy);
      if (tbl[i].chk) check_outputs(i, tbl[i].ev, tbl[i].epc, tbl[i].eocc, tbl[i].eaddr);
      @(posedge clk);
      #1;
    end

    // Randomized phase, starting from a reset
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    model_step(1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      logic        r, d, y;
      logic [31:0] p;
      r = ($urandom_range(0, 199) == 0);
      d = ($urandom_range(0, 15) == 0);
      y = ($urandom_range(0, 9) < 6);
      p = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
      drive(r, d, p, y);
      check_outputs(1000 + c, (m_q.size() > 0), (m_q.size() > 0) ? m_q[0] : 32'h0,
                    m_q.size(), m_fpc);
      model_step(r, d, p, y);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
